// File: rtl/seg_scan_driver_pkg.sv
// seg_scan_driver_pkg: shared 7-segment display types and hex glyph table
//   seg_t   : segment byte in output bit order {dp,g,f,e,d,c,b,a}, active-high
//   HEX_SEG : glyphs for nibbles 0..F as {g,f,e,d,c,b,a}, indexed by nibble value
package seg_scan_driver_pkg;
    localparam int DIGITS = 8;
    typedef struct packed {
        logic       dp;
        logic [6:0] gfedcba;
    } seg_t;
    localparam logic [15:0][6:0] HEX_SEG = {
        7'h71, 7'h79, 7'h5E, 7'h39, 7'h7C, 7'h77, 7'h6F, 7'h7F,
        7'h07, 7'h7D, 7'h6D, 7'h66, 7'h4F, 7'h5B, 7'h06, 7'h3F
    };
endpackage

// File: rtl/seg_hex_decode.sv
// seg_hex_decode: combinational hex nibble to 7-segment glyph
//   nibble_i : hex digit 0..F
//   seg_o    : {g,f,e,d,c,b,a}, active-high
module seg_hex_decode
    import seg_scan_driver_pkg::*;
(
    input  logic [3:0] nibble_i,
    output logic [6:0] seg_o
);
    assign seg_o = HEX_SEG[nibble_i];
endmodule

// File: rtl/seg_scan_driver.sv
// seg_scan_driver: multiplexed 8-digit hex display scanner with blanking and zero suppression
//   clk         : system clock
//   rst         : asynchronous active-low reset
//   display_num : eight hex digits, digit i at [4i+3:4i], latched once per frame
//   zero_blank  : leading-zero suppression enable, sampled live
//   an          : one-hot digit enable (or all-zero), registered
//   seg         : {dp,g,f,e,d,c,b,a}, registered, dp always 0
//   frame_done  : one-cycle pulse on the cycle the new frame word is latched
module seg_scan_driver
    import seg_scan_driver_pkg::*;
#(
    parameter int SCAN_DIV     = 100000,
    parameter int BLANK_CYCLES = 2000
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [31:0]        display_num,
    input  logic               zero_blank,
    output logic [DIGITS-1:0]  an,
    output logic [7:0]         seg,
    output logic               frame_done
);
    localparam int PW = $clog2(SCAN_DIV);
    logic [PW-1:0]     p_q, p_d;
    logic [2:0]        k_q, k_d;
    logic [31:0]       shadow_q, shadow_d;
    logic [DIGITS-1:0] an_q, an_d;
    seg_t              seg_q, seg_d;
    logic [6:0]        dec;
    logic              wrap, lit;
    seg_hex_decode u_dec (
        .nibble_i (shadow_q[{k_q, 2'b00} +: 4]),
        .seg_o    (dec)
    );
    assign wrap       = p_q == PW'(SCAN_DIV - 1);
    assign frame_done = wrap && k_q == 3'd7;
    always_comb begin
        p_d      = wrap ? '0 : p_q + 1'b1;
        k_d      = wrap ? k_q + 3'd1 : k_q;
        shadow_d = frame_done ? display_num : shadow_q;
        // a digit is dark while blanking, or when it and every digit left of it is zero
        lit      = p_q >= PW'(BLANK_CYCLES) &&
                   !(zero_blank && k_q != 3'd0 && (shadow_q >> {k_q, 2'b00}) == 32'd0);
        an_d     = lit ? DIGITS'(1) << k_q : '0;
        seg_d    = lit ? seg_t'{dp: 1'b0, gfedcba: dec} : '0;
    end
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            p_q      <= '0;
            k_q      <= '0;
            shadow_q <= '0;
            an_q     <= '0;
            seg_q    <= '0;
        end else begin
            p_q      <= p_d;
            k_q      <= k_d;
            shadow_q <= shadow_d;
            an_q     <= an_d;
            seg_q    <= seg_d;
        end
    end
    assign an  = an_q;
    assign seg = seg_q;
endmodule

// File: tb/tb_seg_scan_driver.sv
// tb_seg_scan_driver: directed self-checking bench for seg_scan_driver (SCAN_DIV=8, BLANK_CYCLES=2)
module tb_seg_scan_driver;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] display_num = '0;
    logic        zero_blank = 1'b0;
    logic [7:0]  an;
    logic [7:0]  seg;
    logic        frame_done;
    int          n_vec = 0;
    int          n_err = 0;

    seg_scan_driver #(.SCAN_DIV(8), .BLANK_CYCLES(2)) dut (
        .clk         (clk),
        .rst         (rst),
        .display_num (display_num),
        .zero_blank  (zero_blank),
        .an          (an),
        .seg         (seg),
        .frame_done  (frame_done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    // Entered with the scanner at p=0,k=0. After each step, an/seg reflect slot
    // state j while frame_done reflects state j+1, so the pulse lands at j=62.
    // segs is {k7..k0}; lit marks digits expected visible after blanking.
    task automatic check_frame(input string tag, input logic [7:0][7:0] segs,
                               input logic [7:0] lit, input int chg_at,
                               input logic [31:0] chg_val);
        for (int j = 0; j < 64; j++) begin
            int p = j % 8;
            int k = j / 8;
            logic [7:0] ea;
            step();
            ea = (p < 2 || !lit[k]) ? 8'h00 : 8'h01 << k;
            chk($sformatf("%s an j=%0d", tag, j), an, ea);
            chk($sformatf("%s seg j=%0d", tag, j), seg, ea == 8'h00 ? 8'h00 : segs[k]);
            chk($sformatf("%s frame_done j=%0d", tag, j), frame_done, j == 62);
            if (j == chg_at) display_num = chg_val;
        end
    endtask

    initial begin
        #2 rst = 1'b0;
        display_num = 32'hDEADBEEF;
        #1;
        chk("reset async an", an, 8'h00);
        chk("reset async seg", seg, 8'h00);
        repeat (3) step();
        chk("reset hold an", an, 8'h00);
        chk("reset hold seg", seg, 8'h00);
        chk("reset hold frame_done", frame_done, 1'b0);
        display_num = 32'h01234567;
        rst = 1'b1;
        check_frame("first", {8{8'h3F}}, 8'hFF, -1, '0);
        display_num = 32'h11111111;
        check_frame("basic", {8'h3F, 8'h06, 8'h5B, 8'h4F, 8'h66, 8'h6D, 8'h7D, 8'h07},
                    8'hFF, -1, '0);
        check_frame("tear_old", {8{8'h06}}, 8'hFF, 25, 32'h22222222);
        check_frame("tear_new", {8{8'h5B}}, 8'hFF, 62, 32'h00000A05);
        zero_blank = 1'b1;
        check_frame("zblank", {40'h0, 8'h77, 8'h3F, 8'h6D}, 8'h07, 62, 32'h00000000);
        check_frame("allzero", {56'h0, 8'h3F}, 8'h01, -1, '0);
        zero_blank = 1'b0;
        check_frame("zb_live", {8{8'h3F}}, 8'hFF, -1, '0);
        repeat (44) step();
        chk("pre_rst an", an, 8'h20);
        chk("pre_rst seg", seg, 8'h3F);
        rst = 1'b0;
        #1;
        chk("mid_rst async an", an, 8'h00);
        chk("mid_rst async seg", seg, 8'h00);
        chk("mid_rst frame_done", frame_done, 1'b0);
        display_num = 32'h000000C0;
        repeat (2) step();
        chk("mid_rst hold an", an, 8'h00);
        chk("mid_rst hold frame_done", frame_done, 1'b0);
        rst = 1'b1;
        check_frame("restart", {8{8'h3F}}, 8'hFF, -1, '0);
        zero_blank = 1'b1;
        check_frame("c0", {48'h0, 8'h39, 8'h3F}, 8'h03, -1, '0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/seg_scan_driver.md
SEG_SCAN_DRIVER -- requirements
Module: seg_scan_driver

Interface
REQ-001 SHALL have parameter SCAN_DIV, default 100000, giving clock cycles per digit slot (1 kHz digit rate at 100 MHz); legal values are 2 and above.
REQ-002 SHALL have parameter BLANK_CYCLES, default 2000, giving anti-ghost blanking cycles at the start of each slot; legal values are 0 to SCAN_DIV-1.
REQ-003 SHALL have port clk, input, 1 bit: 100 MHz system clock, the only clock.
REQ-004 SHALL have port rst, input, 1 bit: reset, asynchronous, active-low.
REQ-005 SHALL have port display_num, input, 32 bits: eight hex nibbles; digit i = display_num[4i+3:4i]; digit 7 is leftmost.
REQ-006 SHALL have port zero_blank, input, 1 bit: leading-zero suppression enable.
REQ-007 SHALL have port an, output, 8 bits: digit enables, active-high, one-hot or all-zero.
REQ-008 SHALL have port seg, output, 8 bits: {dp,g,f,e,d,c,b,a}, active-high; dp is always 0.
REQ-009 SHALL have port frame_done, output, 1 bit: one-cycle pulse when a new frame is latched.

Function
REQ-010 SHALL keep prescaler p, counting 0..SCAN_DIV-1 and wrapping to 0.
REQ-011 SHALL keep a 3-bit digit index k that increments when p==SCAN_DIV-1 and wraps from 7 to 0.
REQ-012 SHALL load display_num into a 32-bit shadow register on the cycle where p==SCAN_DIV-1 and k==7 (frame boundary), and pulse frame_done high on that same cycle only.
REQ-013 SHALL ignore display_num changes between frame boundaries; the whole frame shows one coherent word (no tearing).
REQ-014 SHALL drive an and seg from registers, so they reflect the p/k/shadow values of the previous cycle (1-cycle latency).
REQ-015 SHALL hold an=0 and seg=0 during blanking (p < BLANK_CYCLES); otherwise an[k]=1 and seg = decode(shadow nibble k).
REQ-016 SHALL decode nibbles 0-F as seg[6:0]: 3F, 06, 5B, 4F, 66, 6D, 7D, 07, 7F, 6F, 77, 7C, 39, 5E, 79, 71.
REQ-017 SHALL suppress digit k (an=0, seg=0 for the whole slot) when zero_blank=1, k!=0, and shadow nibbles k..7 are all zero.
REQ-018 SHALL never suppress digit 0; an all-zero word shows a single "0".
REQ-019 SHALL sample zero_blank live on every cycle; it is not shadowed.
REQ-020 SHALL give frame_done and the shadow load priority; a same-cycle change of display_num is captured.

Reset
REQ-021 SHALL, while rst=0, force p=0, k=0, shadow=0, an=0, seg=0 and frame_done=0 immediately, regardless of clk.
REQ-022 SHALL, after rst release, start scanning at k=0 with p=0, so the first frame displays shadow=0 until the first frame boundary.
REQ-023 SHALL, on reset mid-frame, discard the partial frame; no frame_done is emitted for it.

Structure
REQ-024 SHALL place the 16-entry hex-to-segment table and the seg bit-order constants in the shared display package, for reuse by other display consumers.
REQ-025 SHALL use one sub-module, seg_hex_decode (combinational nibble to seg[6:0]); the counters, shadow register and suppression logic stay in the top module.

Verification (bench uses SCAN_DIV=8, BLANK_CYCLES=2)
REQ-026 SHALL cover reset: hold rst=0 with any display_num -> an=00, seg=00, frame_done=0; after release, the first frame shows seg=3F on each digit.
REQ-027 SHALL cover basic scan: display_num=32'h01234567, zero_blank=0, run to the first frame_done -> slot k=0 shows an=01, seg=07 for 6 cycles after 2 blank cycles; slot k=7 shows an=80, seg=3F; frame_done pulses every 64 cycles.
REQ-028 SHALL cover tearing: change display_num from 32'h11111111 to 32'h22222222 during k=3 -> all digits of the current frame show 06; 5B appears only after the next frame_done.
REQ-029 SHALL cover leading-zero suppression: zero_blank=1, display_num=32'h00000A05 -> digits 7..3 stay dark; digit 2 shows 77, digit 1 shows 3F, digit 0 shows 6D.
REQ-030 SHALL cover the all-zero word: zero_blank=1, display_num=0 -> only an=01 is ever asserted, with seg=3F.
REQ-031 SHALL cover reset mid-operation: assert rst at k=5, p=4 -> outputs 0 within the same cycle; after release, scanning restarts at k=0 and the first frame_done comes 64 cycles later.
